ctrl_pipe: RTL and testbench

Pipeline carrier and hazard controller for the control word produced by the opcode decoder. It takes the decoded ID-stage control signals (RegWrite, ALU_Src, MemRead, MemWrite, MemToReg, Branch, ALU_Op) and register indices. It stages them through ID/EX, EX/MEM and MEM/WB. It detects load-use hazards and taken-branch flushes, then injects bubbles and drives stall/flush to the fetch side. Two saturating event counters are included for performance bring-up.

---
 rtl/ctrl_pipe_if.sv | 59 +++++
 rtl/ctrl_pipe.sv | 130 +++++++++++++
 tb/tb_ctrl_pipe.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pipe_if.sv
// ============================================================================
// ctrl_pipe_if : ID-side control word in, staged control and hazard status out
// Revision 1.0
// ============================================================================
`default_nettype none

interface ctrl_pipe_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic             id_reg_write;
  logic             id_alu_src;
  logic             id_mem_read;
  logic             id_mem_write;
  logic             id_mem_to_reg;
  logic             id_branch;
  logic [1:0]       id_alu_op;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [4:0]       id_rd;
  logic             ex_branch_taken;

  logic             stall;
  logic             flush;
  logic             ex_alu_src;
  logic             ex_branch;
  logic             ex_mem_read;
  logic [1:0]       ex_alu_op;
  logic [4:0]       ex_rd;
  logic             mem_mem_read;
  logic             mem_mem_write;
  logic             mem_reg_write;
  logic [4:0]       mem_rd;
  logic             wb_reg_write;
  logic             wb_mem_to_reg;
  logic [4:0]       wb_rd;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_valid, id_reg_write, id_alu_src, id_mem_read, id_mem_write,
           id_mem_to_reg, id_branch, id_alu_op, id_rs1, id_rs2, id_rd,
           ex_branch_taken,
    input  stall, flush, ex_alu_src, ex_branch, ex_mem_read, ex_alu_op, ex_rd,
           mem_mem_read, mem_mem_write, mem_reg_write, mem_rd,
           wb_reg_write, wb_mem_to_reg, wb_rd, stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_reg_write, id_alu_src, id_mem_read, id_mem_write,
           id_mem_to_reg, id_branch, id_alu_op, id_rs1, id_rs2, id_rd,
           ex_branch_taken,
    output stall, flush, ex_alu_src, ex_branch, ex_mem_read, ex_alu_op, ex_rd,
           mem_mem_read, mem_mem_write, mem_reg_write, mem_rd,
           wb_reg_write, wb_mem_to_reg, wb_rd, stall_count, flush_count
  );
endinterface

`default_nettype wire

// File: rtl/ctrl_pipe.sv
// ============================================================================
// ctrl_pipe : ID/EX, EX/MEM, MEM/WB control staging with load-use/branch hazards
// Revision 1.0
// ============================================================================
`default_nettype none

module ctrl_pipe #(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  ctrl_pipe_if.slave  bus
);

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic [1:0] alu_op;
    logic [4:0] rd;
  } idex_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic [4:0] rd;
  } exmem_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] rd;
  } memwb_t;

  idex_t            idex_q,  idex_d;
  exmem_t           exmem_q, exmem_d;
  memwb_t           memwb_q, memwb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic rs2_used;
  logic luh;
  logic bt;
  logic stall_w;
  logic flush_w;

  always_comb begin
    rs2_used = ~bus.id_alu_src | bus.id_mem_write;
    luh      = bus.id_valid & idex_q.mem_read & (idex_q.rd != 5'd0) &
               ((idex_q.rd == bus.id_rs1) | (rs2_used & (idex_q.rd == bus.id_rs2)));
    bt       = idex_q.branch & bus.ex_branch_taken;
    // Flush wins over stall; both are silenced while reset is held.
    flush_w  = ~rst & bt;
    stall_w  = ~rst & luh & ~bt;
  end

  always_comb begin
    idex_d = '0;
    if (bus.id_valid && !luh && !bt) begin
      idex_d.reg_write  = bus.id_reg_write;
      idex_d.alu_src    = bus.id_alu_src;
      idex_d.mem_read   = bus.id_mem_read;
      idex_d.mem_write  = bus.id_mem_write;
      idex_d.mem_to_reg = bus.id_mem_to_reg;
      idex_d.branch     = bus.id_branch;
      idex_d.alu_op     = bus.id_alu_op;
      idex_d.rd         = bus.id_rd;
    end

    exmem_d.reg_write  = idex_q.reg_write;
    exmem_d.mem_read   = idex_q.mem_read;
    exmem_d.mem_write  = idex_q.mem_write;
    exmem_d.mem_to_reg = idex_q.mem_to_reg;
    exmem_d.rd         = idex_q.rd;

    memwb_d.reg_write  = exmem_q.reg_write;
    memwb_d.mem_to_reg = exmem_q.mem_to_reg;
    memwb_d.rd         = exmem_q.rd;

    stall_cnt_d = stall_cnt_q;
    if (stall_w && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    flush_cnt_d = flush_cnt_q;
    if (flush_w && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q      <= '0;
      exmem_q     <= '0;
      memwb_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      idex_q      <= idex_d;
      exmem_q     <= exmem_d;
      memwb_q     <= memwb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall         = stall_w;
  assign bus.flush         = flush_w;
  assign bus.ex_alu_src    = idex_q.alu_src;
  assign bus.ex_branch     = idex_q.branch;
  assign bus.ex_mem_read   = idex_q.mem_read;
  assign bus.ex_alu_op     = idex_q.alu_op;
  assign bus.ex_rd         = idex_q.rd;
  assign bus.mem_mem_read  = exmem_q.mem_read;
  assign bus.mem_mem_write = exmem_q.mem_write;
  assign bus.mem_reg_write = exmem_q.reg_write;
  assign bus.mem_rd        = exmem_q.rd;
  assign bus.wb_reg_write  = memwb_q.reg_write;
  assign bus.wb_mem_to_reg = memwb_q.mem_to_reg;
  assign bus.wb_rd         = memwb_q.rd;
  assign bus.stall_count   = stall_cnt_q;
  assign bus.flush_count   = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
// ============================================================================
// tb_ctrl_pipe : directed scoreboard bench for ctrl_pipe (CNT_W=16 and CNT_W=2)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ctrl_pipe;

  typedef struct packed {
    logic       valid;
    logic       rw;
    logic       asrc;
    logic       mr;
    logic       mw;
    logic       m2r;
    logic       br;
    logic [1:0] op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } ctl_t;

  typedef struct packed {
    logic       rw;
    logic       asrc;
    logic       mr;
    logic       mw;
    logic       m2r;
    logic       br;
    logic [1:0] op;
    logic [4:0] rd;
  } ew_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ctl_t id  = '0;
  logic btk = 1'b0;

  int errors = 0;
  int checks = 0;

  ew_t ex_m = '0, mem_m = '0, wb_m = '0;
  ew_t exp_q[$];
  int  s16 = 0, f16 = 0, s2 = 0, f2 = 0;

  ctrl_pipe_if #(.CNT_W(16)) b16 ();
  ctrl_pipe_if #(.CNT_W(2))  b2  ();

  ctrl_pipe #(.CNT_W(16)) u16 (.clk(clk), .rst(rst), .bus(b16.slave));
  ctrl_pipe #(.CNT_W(2))  u2  (.clk(clk), .rst(rst), .bus(b2.slave));

  always #5 clk = ~clk;

  assign b16.id_valid        = id.valid;
  assign b16.id_reg_write    = id.rw;
  assign b16.id_alu_src      = id.asrc;
  assign b16.id_mem_read     = id.mr;
  assign b16.id_mem_write    = id.mw;
  assign b16.id_mem_to_reg   = id.m2r;
  assign b16.id_branch       = id.br;
  assign b16.id_alu_op       = id.op;
  assign b16.id_rs1          = id.rs1;
  assign b16.id_rs2          = id.rs2;
  assign b16.id_rd           = id.rd;
  assign b16.ex_branch_taken = btk;

  assign b2.id_valid        = id.valid;
  assign b2.id_reg_write    = id.rw;
  assign b2.id_alu_src      = id.asrc;
  assign b2.id_mem_read     = id.mr;
  assign b2.id_mem_write    = id.mw;
  assign b2.id_mem_to_reg   = id.m2r;
  assign b2.id_branch       = id.br;
  assign b2.id_alu_op       = id.op;
  assign b2.id_rs1          = id.rs1;
  assign b2.id_rs2          = id.rs2;
  assign b2.id_rd           = id.rd;
  assign b2.ex_branch_taken = btk;

  function automatic ctl_t rtype(input logic [4:0] rd, rs1, rs2);
    ctl_t c = '0;
    c.valid = 1'b1; c.rw = 1'b1; c.op = 2'b10;
    c.rd = rd; c.rs1 = rs1; c.rs2 = rs2;
    return c;
  endfunction

  function automatic ctl_t itype(input logic [4:0] rd, rs1, rs2);
    ctl_t c = rtype(rd, rs1, rs2);
    c.asrc = 1'b1; c.op = 2'b11;
    return c;
  endfunction

  function automatic ctl_t load(input logic [4:0] rd, rs1);
    ctl_t c = '0;
    c.valid = 1'b1; c.rw = 1'b1; c.asrc = 1'b1; c.mr = 1'b1; c.m2r = 1'b1;
    c.rd = rd; c.rs1 = rs1; c.rs2 = 5'd0;
    return c;
  endfunction

  function automatic ctl_t store(input logic [4:0] rd, rs1, rs2);
    ctl_t c = '0;
    c.valid = 1'b1; c.asrc = 1'b1; c.mw = 1'b1;
    c.rd = rd; c.rs1 = rs1; c.rs2 = rs2;
    return c;
  endfunction

  function automatic ew_t to_ew(input ctl_t c);
    ew_t e;
    e.rw = c.rw; e.asrc = c.asrc; e.mr = c.mr; e.mw = c.mw;
    e.m2r = c.m2r; e.br = c.br; e.op = c.op; e.rd = c.rd;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ex_alu_src",    32'(b16.ex_alu_src),    32'(ex_m.asrc));
    chk("ex_branch",     32'(b16.ex_branch),     32'(ex_m.br));
    chk("ex_mem_read",   32'(b16.ex_mem_read),   32'(ex_m.mr));
    chk("ex_alu_op",     32'(b16.ex_alu_op),     32'(ex_m.op));
    chk("ex_rd",         32'(b16.ex_rd),         32'(ex_m.rd));
    chk("mem_mem_read",  32'(b16.mem_mem_read),  32'(mem_m.mr));
    chk("mem_mem_write", 32'(b16.mem_mem_write), 32'(mem_m.mw));
    chk("mem_reg_write", 32'(b16.mem_reg_write), 32'(mem_m.rw));
    chk("mem_rd",        32'(b16.mem_rd),        32'(mem_m.rd));
    chk("wb_reg_write",  32'(b16.wb_reg_write),  32'(wb_m.rw));
    chk("wb_mem_to_reg", 32'(b16.wb_mem_to_reg), 32'(wb_m.m2r));
    chk("wb_rd",         32'(b16.wb_rd),         32'(wb_m.rd));
    chk("stall_count",   32'(b16.stall_count),   32'(s16));
    chk("flush_count",   32'(b16.flush_count),   32'(f16));
    chk("stall_count_w2", 32'(b2.stall_count),   32'(s2));
    chk("flush_count_w2", 32'(b2.flush_count),   32'(f2));
    chk("ex_rd_w2",      32'(b2.ex_rd),          32'(ex_m.rd));
  endtask

  // One clock with the current ID inputs; es/ef are the expected stall/flush.
  task automatic step(input logic es, input logic ef);
    @(negedge clk);
    chk("stall",    32'(b16.stall), 32'(es));
    chk("flush",    32'(b16.flush), 32'(ef));
    chk("stall_w2", 32'(b2.stall),  32'(es));
    if (es || ef || !id.valid) exp_q.push_back('0);
    else                       exp_q.push_back(to_ew(id));
    if (es) begin
      if (s16 < 65535) s16++;
      if (s2 < 3)      s2++;
    end
    if (ef) begin
      if (f16 < 65535) f16++;
      if (f2 < 3)      f2++;
    end
    @(posedge clk); #1;
    wb_m  = mem_m;
    mem_m = ex_m;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      ex_m = '0;
    end else begin
      ex_m = exp_q.pop_front();
    end
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_stall", 32'(b16.stall), 32'd0);
    chk("rst_flush", 32'(b16.flush), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    ex_m = '0; mem_m = '0; wb_m = '0;
    s16 = 0; f16 = 0; s2 = 0; f2 = 0;
    check_all();
  endtask

  ctl_t odd;

  initial begin
    do_reset();

    // R-type flows ex -> mem -> wb in consecutive cycles
    id = rtype(5'd5, 5'd1, 5'd2);      step(1'b0, 1'b0);
    id = '0;                           step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // load-use on rs2: one stall, consumer issues a cycle late
    id = load(5'd3, 5'd1);             step(1'b0, 1'b0);
    id = rtype(5'd6, 5'd4, 5'd3);      step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    id = '0;                           step(1'b0, 1'b0);

    // rd=0 never creates a hazard
    id = load(5'd0, 5'd1);             step(1'b0, 1'b0);
    id = rtype(5'd7, 5'd0, 5'd0);      step(1'b0, 1'b0);

    // I-type ignores rs2; store uses it
    id = load(5'd3, 5'd1);             step(1'b0, 1'b0);
    id = itype(5'd8, 5'd1, 5'd3);      step(1'b0, 1'b0);
    id = load(5'd3, 5'd1);             step(1'b0, 1'b0);
    id = store(5'd7, 5'd1, 5'd3);      step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // branch taken coinciding with a load-use: flush wins
    odd = load(5'd3, 5'd1);
    odd.br = 1'b1; odd.op = 2'b01;
    id = odd;                          step(1'b0, 1'b0);
    id = rtype(5'd9, 5'd3, 5'd2);
    btk = 1'b1;                        step(1'b0, 1'b1);

    // taken flag without a branch in EX is ignored
    id = rtype(5'd10, 5'd1, 5'd2);     step(1'b0, 1'b0);
    id = rtype(5'd11, 5'd1, 5'd2);     step(1'b0, 1'b0);
    btk = 1'b0;

    // invalid ID word becomes a bubble, and cannot trigger a load-use
    id = load(5'd3, 5'd1);             step(1'b0, 1'b0);
    id = rtype(5'd12, 5'd3, 5'd3);
    id.valid = 1'b0;                   step(1'b0, 1'b0);
    id = '0;                           step(1'b0, 1'b0);

    // five stall events: narrow counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      id = load(5'd4, 5'd1);           step(1'b0, 1'b0);
      id = rtype(5'd13, 5'd4, 5'd1);   step(1'b1, 1'b0);
    end
    id = '0;                           step(1'b0, 1'b0);

    // reset during a stall leaves a clean pipe
    id = load(5'd3, 5'd1);             step(1'b0, 1'b0);
    id = rtype(5'd14, 5'd3, 5'd2);     do_reset();
    step(1'b0, 1'b0);
    id = '0;                           step(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
